// File: rtl/rand_word_arbiter_if.sv
// Requester-side bus of rand_word_arbiter: level requests in,
// one-hot grant, assembled word and valid/ack pulses out.
interface rand_word_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8
);
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] grant_o;
  logic [WORD_W-1:0]  word_o;
  logic               valid_o;
  logic [NUM_REQ-1:0] ack_o;

  // Arbiter side
  modport slave (
    input  req_i,
    output grant_o,
    output word_o,
    output valid_o,
    output ack_o
  );

  // Requester side
  modport master (
    output req_i,
    input  grant_o,
    input  word_o,
    input  valid_o,
    input  ack_o
  );
endinterface

// File: rtl/rand_word_arbiter.sv
// Round-robin arbiter sharing one serial random-bit generator among
// NUM_REQ requesters. The winner's word is assembled MSB-first from
// WORD_W consecutive generator bits and returned with a one-cycle
// valid/ack pulse. Generator enable is high only while collecting.
module rand_word_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rand_word_arbiter_if.slave   bus,
  output logic                 lfsr_en_o,
  input  logic                 lfsr_rand_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (WORD_W  > 1) ? $clog2(WORD_W)  : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic [WORD_W-1:0]  r_shreg;
  logic [WORD_W-1:0]  r_word;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_win_found;
  logic [PTR_W-1:0]   w_win_idx;
  logic [PTR_W-1:0]   w_next_ptr;
  logic               w_abort;
  logic               w_last;
  logic [WORD_W-1:0]  w_shifted;

  // Round-robin search: first set request at or above r_ptr, wrapping.
  always_comb begin : win_search
    logic [PTR_W:0] v_idx;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    v_idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_idx = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (v_idx >= (PTR_W+1)'(NUM_REQ)) begin
        v_idx = v_idx - (PTR_W+1)'(NUM_REQ);
      end else begin
        v_idx = v_idx;
      end
      if (!w_win_found && bus.req_i[v_idx[PTR_W-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = v_idx[PTR_W-1:0];
      end else begin
        w_win_found = w_win_found;
      end
    end
  end

  // Pointer successor, collection abort/finish conditions and shifted word.
  always_comb begin
    w_next_ptr = '0;
    if (r_owner == PTR_W'(NUM_REQ-1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = r_owner + PTR_W'(1);
    end
    w_abort   = (r_state == S_COLLECT) && ((bus.req_i & r_grant) == '0);
    w_last    = (r_cnt == CNT_W'(WORD_W-1));
    w_shifted = {r_shreg[WORD_W-2:0], lfsr_rand_i};
  end

  // Next-state decision; abort has priority over finishing the word.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_next_state = S_COLLECT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (w_abort) begin
          w_next_state = S_IDLE;
        end else if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_COLLECT;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grant, pointer, bit collection and word delivery registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_shreg <= '0;
      r_word  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_found) begin
            r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;
            r_owner <= w_win_idx;
            r_cnt   <= '0;
            r_shreg <= '0;
          end
        end
        S_COLLECT: begin
          if (w_abort) begin
            // Bits already pulled from the generator are simply dropped.
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
          end else begin
            r_shreg <= w_shifted;
            if (w_last) begin
              // Counter holds at its final value instead of wrapping.
              r_word <= w_shifted;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          r_grant <= '0;
          r_ptr   <= w_next_ptr;
        end
        default: begin
          r_grant <= '0;
        end
      endcase
    end
  end

  // Outputs decoded purely from registered state; no path from req_i.
  assign lfsr_en_o   = (r_state == S_COLLECT);
  assign bus.valid_o = (r_state == S_DONE);
  assign bus.ack_o   = (r_state == S_DONE) ? r_grant : '0;
  assign bus.grant_o = r_grant;
  assign bus.word_o  = r_word;

endmodule
